fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage of the 16-bit multi-cycle processor. Sits directly upstream of the controller FSM.
- Owns the program counter (PC) and the instruction register (IR).
- Runs the instruction-memory read handshake when the controller requests a fetch.
- Applies unconditional and conditional (Eq/Neq) PC writes, and supplies the opcode field Op plus the decoded register and immediate fields to the controller and datapath.

Parameters:
- RESET_PC, 16'h0000, PC value after reset.
- TIMEOUT, 16, cycles allowed for ImValid when FETCH_TIMEOUT_EN is defined (range 2..255).

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- IMRead  input  1  controller fetch request (one-cycle pulse).
- IRWrite  input  1  when high together with IMRead, the returned word is loaded into IR.
- PCWrite  input  1  unconditional PC write.
- PCWriteCondEq  input  1  PC write if Zero=1.
- PCWriteCondNeq  input  1  PC write if Zero=0.
- PCSrc  input  1  PC source: 0 = ALUResult, 1 = BrTarget.
- Zero  input  1  ALU zero flag.
- ALUResult  input  16  ALU output (PC+1 / jump target).
- BrTarget  input  16  registered branch target from datapath.
- ImAddr  output  16  instruction-memory address.
- ImReq  output  1  instruction-memory read request.
- ImRdata  input  16  instruction-memory read data.
- ImValid  input  1  ImRdata valid (one-cycle pulse).
- FetchBusy  output  1  fetch in progress; the controller holds state while high.
- Op  output  4  IR[15:12].
- Rd  output  4  IR[11:8].
- Rs  output  4  IR[7:4].
- Rt  output  4  IR[3:0].
- Imm8  output  8  IR[7:0].
- PC  output  16  current PC.
- FetchErr  output  1  sticky fetch-timeout flag (0 when the feature is compiled out).

Behaviour:
- Reset (asynchronous, any state): PC=RESET_PC, IR=16'h0000, state=IDLE, ImReq=0, ImAddr=0, FetchBusy=0, FetchErr=0, latched IRWrite=0.
- PC load enable = PCWrite | (PCWriteCondEq & Zero) | (PCWriteCondNeq & ~Zero). On the clock edge, PC <= PCSrc ? BrTarget : ALUResult. PC is 16-bit and wraps (16'hFFFF+1 = 16'h0000). PC updates independently of fetch state.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - On IMRead=1: capture ImAddr<=PC (the pre-update PC, even if PCWrite is high in the same cycle), latch IRWrite, assert FetchBusy, go to REQ.
  - Otherwise stay in IDLE.
- REQ: ImReq=1 for exactly one cycle, then go to WAIT. An ImValid seen in REQ is accepted as if in WAIT.
- WAIT: ImReq=0 and ImAddr held. On ImValid=1:
  - If latched IRWrite=1, IR<=ImRdata; otherwise IR is unchanged.
  - Go to IDLE; FetchBusy deasserts in the next cycle.
- Latency: IR visible (and Op valid) 1 cycle after the ImValid edge. Minimum fetch is 3 cycles from IMRead to Op valid with zero-wait memory (ImValid in the cycle after ImReq).
- FetchBusy = 1 in REQ and WAIT, and in IDLE only while IMRead is being accepted.
- IMRead while in REQ/WAIT: ignored; no second request is issued.
- ImValid in IDLE: ignored, IR unchanged.
- Reset mid-fetch: request aborted, state returns to IDLE, and a late ImValid is ignored.
- Op, Rd, Rs, Rt, and Imm8 are pure slices of the IR register: glitch-free and stable between IR loads.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to REQ and increments each cycle in REQ/WAIT.
  - When it reaches TIMEOUT without ImValid: FetchErr<=1 (sticky until Reset), state<=IDLE, IR unchanged, FetchBusy drops.
  - If ImValid arrives in the same cycle as the expiry, ImValid wins and no error is raised.
- Not defined: no counter; WAIT holds indefinitely; FetchErr tied 0.

Test Plan:
- Reset with RESET_PC=16'h0010, then IMRead+IRWrite+PCWrite pulse with PCSrc=0, ALUResult=16'h0011, zero-wait memory returning 16'h8123 -> ImAddr=16'h0010, PC=16'h0011 the next cycle, Op=4'h8, Rd=1, Rs=2, Rt=3, FetchBusy high for 3 cycles.
- PCWriteCondEq=1 with Zero=1, PCSrc=1, BrTarget=16'h0040 -> PC=16'h0040. Repeat with Zero=0 -> PC unchanged. Repeat with PCWriteCondNeq=1, Zero=0 -> PC=16'h0040.
- IMRead with IRWrite=0, memory returns 16'hFFFF -> IR keeps its previous value, FetchBusy clears.
- Memory with 5 wait cycles; second IMRead pulsed during WAIT -> only one ImReq pulse; IR loaded once, after ImValid.
- Assert Reset during WAIT, then pulse ImValid with 16'h1234 -> IR=16'h0000, state IDLE, PC=RESET_PC.
- With FETCH_TIMEOUT_EN and TIMEOUT=16, memory never responds -> FetchErr=1 at cycle 16 after REQ entry, FetchBusy=0, FetchErr stays high until Reset.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns PC and IR and runs the instruction-memory read handshake.
// Optional fetch timeout with a sticky FetchErr flag is enabled by defining FETCH_TIMEOUT_EN.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        IMRead,
    input  logic        IRWrite,
    input  logic        PCWrite,
    input  logic        PCWriteCondEq,
    input  logic        PCWriteCondNeq,
    input  logic        PCSrc,
    input  logic        Zero,
    input  logic [15:0] ALUResult,
    input  logic [15:0] BrTarget,
    output logic [15:0] ImAddr,
    output logic        ImReq,
    input  logic [15:0] ImRdata,
    input  logic        ImValid,
    output logic        FetchBusy,
    output logic [3:0]  Op,
    output logic [3:0]  Rd,
    output logic [3:0]  Rs,
    output logic [3:0]  Rt,
    output logic [7:0]  Imm8,
    output logic [15:0] PC,
    output logic        FetchErr
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] pc_reg;
    logic [15:0] ir_reg;
    logic [15:0] addr_reg;
    logic        irw_reg;
    logic        pc_load;
    logic        start;
    logic        load_ir;
    logic        tmo_hit;

    assign pc_load = PCWrite | (PCWriteCondEq & Zero) | (PCWriteCondNeq & ~Zero);

    // PC runs independently of the fetch handshake.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pc_reg <= RESET_PC;
        end else if (pc_load) begin
            pc_reg <= PCSrc ? BrTarget : ALUResult;
        end
    end

    always_comb begin
        state_next = state_reg;
        start      = 1'b0;
        load_ir    = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (IMRead) begin
                    start      = 1'b1;
                    state_next = S_REQ;
                end
            end
            S_REQ, S_WAIT: begin
                // A response already present during REQ completes the fetch early.
                if (ImValid) begin
                    load_ir    = irw_reg;
                    state_next = S_IDLE;
                end else if (tmo_hit) begin
                    state_next = S_IDLE;
                end else begin
                    state_next = S_WAIT;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg <= S_IDLE;
            addr_reg  <= 16'h0000;
            irw_reg   <= 1'b0;
            ir_reg    <= 16'h0000;
        end else begin
            state_reg <= state_next;
            if (start) begin
                addr_reg <= pc_reg;
                irw_reg  <= IRWrite;
            end
            if (load_ir) begin
                ir_reg <= ImRdata;
            end
        end
    end

`ifdef FETCH_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    logic [7:0] tmo_cnt_reg;
    logic       err_reg;

    assign tmo_hit = (tmo_cnt_reg == TMO_LAST);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            tmo_cnt_reg <= 8'd0;
            err_reg     <= 1'b0;
        end else begin
            if (start) begin
                tmo_cnt_reg <= 8'd0;
            end else if (state_reg != S_IDLE) begin
                tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
            end
            // ImValid arriving on the expiry cycle takes priority over the error.
            if ((state_reg != S_IDLE) && !ImValid && tmo_hit) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign FetchErr = err_reg;
`else
    assign tmo_hit  = 1'b0;
    assign FetchErr = 1'b0;
`endif

    assign ImReq     = (state_reg == S_REQ);
    assign ImAddr    = addr_reg;
    assign FetchBusy = (state_reg != S_IDLE) | start;
    assign PC        = pc_reg;
    assign Op        = ir_reg[15:12];
    assign Rd        = ir_reg[11:8];
    assign Rs        = ir_reg[7:4];
    assign Rt        = ir_reg[3:0];
    assign Imm8      = ir_reg[7:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: the driver pushes expected requests and
// fetch results, a monitor pops them as the DUT issues ImReq and finishes fetches.
module tb_fetch_unit;

    localparam logic [15:0] RST_PC = 16'h0010;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        IMRead, IRWrite, PCWrite, PCWriteCondEq, PCWriteCondNeq, PCSrc, Zero;
    logic [15:0] ALUResult, BrTarget, ImAddr, ImRdata, PC;
    logic        ImReq, ImValid, FetchBusy, FetchErr;
    logic [3:0]  Op, Rd, Rs, Rt;
    logic [7:0]  Imm8;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] ir;
        int          busy_len;
    } done_t;

    logic [15:0] req_q[$];
    done_t       done_q[$];
    logic [15:0] pc_m;
    logic [15:0] ir_m;

    fetch_unit #(.RESET_PC(RST_PC), .TIMEOUT(16)) dut (
        .Clk(Clk), .Reset(Reset), .IMRead(IMRead), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .PCWriteCondEq(PCWriteCondEq), .PCWriteCondNeq(PCWriteCondNeq),
        .PCSrc(PCSrc), .Zero(Zero), .ALUResult(ALUResult), .BrTarget(BrTarget),
        .ImAddr(ImAddr), .ImReq(ImReq), .ImRdata(ImRdata), .ImValid(ImValid),
        .FetchBusy(FetchBusy), .Op(Op), .Rd(Rd), .Rs(Rs), .Rt(Rt), .Imm8(Imm8),
        .PC(PC), .FetchErr(FetchErr)
    );

    always #5 Clk = ~Clk;

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Reference PC rule: load when written unconditionally or when the condition matches Zero.
    task automatic drive_pc(input bit w, input bit ceq, input bit cneq, input bit src,
                            input bit z, input logic [15:0] alu, input logic [15:0] br);
        PCWrite = w; PCWriteCondEq = ceq; PCWriteCondNeq = cneq;
        PCSrc = src; Zero = z; ALUResult = alu; BrTarget = br;
        if (w || (ceq && z) || (cneq && !z)) pc_m = src ? br : alu;
    endtask

    task automatic idle_ctrl();
        PCWrite = 0; PCWriteCondEq = 0; PCWriteCondNeq = 0;
        PCSrc = 0; Zero = 0; IMRead = 0; ImValid = 0;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        req_q.delete();
        done_q.delete();
        pc_m = RST_PC;
        ir_m = 16'h0000;
        @(negedge Clk);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
    endtask

    task automatic pc_op(input bit w, input bit ceq, input bit cneq, input bit src,
                         input bit z, input logic [15:0] alu, input logic [15:0] br);
        IMRead  = 0;
        ImValid = ($urandom_range(0, 3) == 0);
        ImRdata = 16'($urandom);
        drive_pc(w, ceq, cneq, src, z, alu, br);
        tick();
        idle_ctrl();
        check16("pc_op", PC, pc_m);
    endtask

    // waits < 0 puts ImValid in the REQ cycle; otherwise ImValid comes 'waits' cycles after zero-wait.
    task automatic do_fetch(input bit irw, input int waits, input logic [15:0] data, input bit dup,
                            input bit w, input bit ceq, input bit cneq, input bit src,
                            input bit z, input logic [15:0] alu, input logic [15:0] br);
        done_t d;
        req_q.push_back(pc_m);
        IMRead  = 1;
        IRWrite = irw;
        drive_pc(w, ceq, cneq, src, z, alu, br);
        if (irw) ir_m = data;
        d.ir       = ir_m;
        d.busy_len = (waits < 0) ? 2 : 3 + waits;
        done_q.push_back(d);
        tick();
        check16("pc_fetch", PC, pc_m);
        idle_ctrl();
        IRWrite = 1'($urandom);
        if (waits < 0) begin
            ImValid = 1;
            ImRdata = data;
            tick();
        end else begin
            tick();
            for (int i = 0; i < waits; i++) begin
                IMRead  = dup && (i == waits / 2);
                IRWrite = 1'($urandom);
                ImRdata = 16'($urandom);
                tick();
            end
            IMRead  = 0;
            ImValid = 1;
            ImRdata = data;
            tick();
        end
        ImValid = ($urandom_range(0, 3) == 0);
        ImRdata = 16'($urandom);
        tick();
        ImValid = 0;
    endtask

    initial begin : monitor
        int    busy_cnt;
        done_t d;
        busy_cnt = 0;
        forever begin
            @(negedge Clk);
            if (Reset) begin
                busy_cnt = 0;
            end else begin
                if (ImReq) begin
                    if (req_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL imreq: got request at %h, expected none", ImAddr);
                    end else begin
                        check16("imaddr", ImAddr, req_q.pop_front());
                    end
                end
                if (FetchBusy) begin
                    busy_cnt++;
                end else if (busy_cnt != 0) begin
                    if (done_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL done: got completion, expected none");
                    end else begin
                        d = done_q.pop_front();
                        check16("ir_fields", {Op, Rd, Rs, Rt}, d.ir);
                        check16("imm8", {8'h00, Imm8}, {8'h00, d.ir[7:0]});
                        check16("busy_len", busy_cnt[15:0], d.busy_len[15:0]);
                    end
                    busy_cnt = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        Reset = 1; IRWrite = 0; ImRdata = 0; ALUResult = 0; BrTarget = 0;
        idle_ctrl();
        pc_m = RST_PC;
        ir_m = 16'h0000;
        repeat (2) tick();
        do_reset();
        check16("rst_pc", PC, RST_PC);
        check16("rst_ir", {Op, Rd, Rs, Rt}, 16'h0000);
        check16("rst_imaddr", ImAddr, 16'h0000);
        check16("rst_imreq", {15'h0, ImReq}, 16'h0);
        check16("rst_busy", {15'h0, FetchBusy}, 16'h0);
        check16("rst_err", {15'h0, FetchErr}, 16'h0);

        // Fetch with a PC write in the same cycle; address must be the old PC.
        do_fetch(1, 0, 16'h8123, 0, 1, 0, 0, 0, 0, 16'h0011, 16'h0000);

        pc_op(0, 1, 0, 1, 1, 16'h0005, 16'h0040);
        check16("cond_eq_taken", PC, 16'h0040);
        pc_op(0, 1, 0, 1, 0, 16'h0005, 16'h0077);
        check16("cond_eq_not_taken", PC, 16'h0040);
        pc_op(1, 0, 0, 0, 0, 16'h0011, 16'h0000);
        pc_op(0, 0, 1, 1, 0, 16'h0005, 16'h0040);
        check16("cond_neq_taken", PC, 16'h0040);
        pc_op(1, 0, 0, 0, 0, 16'h0000 - 16'h0001 + 16'h0001, 16'h0000);

        do_fetch(0, 0, 16'hFFFF, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000);
        do_fetch(1, 5, 16'h3A5C, 1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000);

        // Abort a fetch in WAIT; the late response must be ignored.
        req_q.push_back(pc_m);
        IMRead = 1; IRWrite = 1;
        tick();
        IMRead = 0;
        repeat (2) tick();
        do_reset();
        ImValid = 1; ImRdata = 16'h1234;
        tick();
        ImValid = 0;
        check16("abort_ir", {Op, Rd, Rs, Rt}, 16'h0000);
        check16("abort_pc", PC, RST_PC);
        check16("abort_busy", {15'h0, FetchBusy}, 16'h0);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 2) != 0)
                do_fetch(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)) - 1,
                         16'($urandom), 1'($urandom), 1'($urandom_range(0, 2) == 0),
                         1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                         16'($urandom), 16'($urandom));
            else
                pc_op(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                      16'($urandom), 16'($urandom));
        end

`ifdef FETCH_TIMEOUT_EN
        begin
            done_t d;
            req_q.push_back(pc_m);
            d.ir = ir_m;
            d.busy_len = 17;
            done_q.push_back(d);
            IMRead = 1; IRWrite = 1;
            tick();
            IMRead = 0;
            repeat (15) tick();
            check16("tmo_before", {15'h0, FetchErr}, 16'h0);
            tick();
            check16("tmo_err", {15'h0, FetchErr}, 16'h1);
            check16("tmo_busy", {15'h0, FetchBusy}, 16'h0);
            tick();
            do_fetch(1, 1, 16'h5A5A, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000);
            check16("tmo_sticky", {15'h0, FetchErr}, 16'h1);
            do_reset();
            check16("tmo_cleared", {15'h0, FetchErr}, 16'h0);
        end
`else
        check16("err_tied", {15'h0, FetchErr}, 16'h0);
`endif

        repeat (3) tick();
        total++;
        if (req_q.size() != 0 || done_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d requests and %0d fetches outstanding, expected 0",
                     req_q.size(), done_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
